// File: rtl/lcd_text_frame_if.sv
// Host write port plus byte stream toward the HD44780 controller.
// master = frame source (lcd_text_frame), slave = host/controller side.
interface lcd_text_frame_if;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_char;
   logic       refresh;
   logic       ctrl_ready;
   logic       out_valid;
   logic       out_rs;
   logic [7:0] out_data;
   logic       busy;
   logic       frame_done;

   modport master (
      input  wr_en, wr_addr, wr_char, refresh, ctrl_ready,
      output out_valid, out_rs, out_data, busy, frame_done
   );

   modport slave (
      output wr_en, wr_addr, wr_char, refresh, ctrl_ready,
      input  out_valid, out_rs, out_data, busy, frame_done
   );
endinterface

// File: rtl/lcd_text_frame.sv
// 2xCOLS character buffer streamed to the LCD controller as one frame of command/data beats.
// Optional LCD_AUTO_REFRESH_EN: periodic refresh every REFRESH_CYCLES clocks.
module lcd_text_frame #(
   parameter int         COLS           = 16,
   parameter logic [7:0] LINE1_CMD      = 8'h80,
   parameter logic [7:0] LINE2_CMD      = 8'hC0,
   parameter int         REFRESH_CYCLES = 2_500_000
) (
   input  logic             clk,
   input  logic             rst,
   lcd_text_frame_if.master bus
);
   localparam int         DEPTH     = 2 * COLS;
   localparam int         AW        = $clog2(DEPTH);
   localparam logic [5:0] CMD2_BEAT = 6'(COLS + 1);
   localparam logic [5:0] LAST_BEAT = 6'(2 * COLS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

   state_t        state, state_nx;
   logic [7:0]    buf_q [DEPTH];
   logic [5:0]    beat;
   logic          pending;
   logic          valid_q, rs_q;
   logic [7:0]    data_q;
   logic          start, xfer, wr_ok, tick, set_p;
   logic          busy_c, done_c;
   logic [AW-1:0] cidx;
   logic          beat_rs;
   logic [7:0]    beat_data;

   assign start = (state == IDLE) && pending;
   assign xfer  = valid_q && bus.ctrl_ready;
   assign wr_ok = bus.wr_en && (int'(bus.wr_addr) < DEPTH);
   assign set_p = wr_ok || bus.refresh || tick;

`ifdef LCD_AUTO_REFRESH_EN
   localparam int CW = $clog2(REFRESH_CYCLES);
   logic [CW-1:0] rcnt;

   assign tick = (rcnt == CW'(REFRESH_CYCLES - 1));

   // Restarting on frame start keeps timer refreshes from stacking behind host frames.
   always_ff @(posedge clk or negedge rst)
      if (!rst)               rcnt <= '0;
      else if (start || tick) rcnt <= '0;
      else                    rcnt <= rcnt + 1'b1;
`else
   assign tick = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;

   always_comb begin
      state_nx = state;
      busy_c   = 1'b1;
      done_c   = 1'b0;
      unique case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (pending) state_nx = LOAD;
         end
         LOAD: state_nx = SEND;
         SEND: if (xfer) state_nx = (beat == LAST_BEAT) ? DONE : LOAD;
         DONE: begin
            done_c   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Beat k maps to a command or to buf[k-1] (line 1) / buf[k-2] (line 2).
   always_comb begin
      beat_rs   = 1'b1;
      beat_data = LINE1_CMD;
      cidx      = AW'(beat - 6'd1);
      if (beat == 6'd0) begin
         beat_rs   = 1'b0;
         beat_data = LINE1_CMD;
      end else if (beat == CMD2_BEAT) begin
         beat_rs   = 1'b0;
         beat_data = LINE2_CMD;
      end else begin
         cidx      = (beat < CMD2_BEAT) ? AW'(beat - 6'd1) : AW'(beat - 6'd2);
         beat_data = buf_q[cidx];
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h20;
      end else if (wr_ok) begin
         buf_q[bus.wr_addr] <= bus.wr_char;
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pending <= 1'b1;
         beat    <= '0;
         valid_q <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         // A new request on the frame-start edge wins over the clear.
         pending <= set_p || (pending && !start);
         if (start)
            beat <= '0;
         else if (state == SEND && xfer && beat != LAST_BEAT)
            beat <= beat + 6'd1;
         if (state == LOAD) begin
            valid_q <= 1'b1;
            rs_q    <= beat_rs;
            data_q  <= beat_data;
         end else if (xfer) begin
            valid_q <= 1'b0;
         end
      end

   assign bus.out_valid  = valid_q;
   assign bus.out_rs     = rs_q;
   assign bus.out_data   = data_q;
   assign bus.busy       = busy_c;
   assign bus.frame_done = done_c;
endmodule
